// File: rtl/exc_requester_pkg.sv
// rtl/exc_requester_pkg.sv - shared constants for the MEM-stage exception requester
//
// Holds exc_type bit positions, mem_flags bit positions, badvaddr select codes,
// the requester FSM encoding and the general exception vector.
package exc_requester_pkg;

    // exc_type one-hot bit positions as seen by CP0
    localparam int EXC_BRK     = 0;
    localparam int EXC_SYSCALL = 1;
    localparam int EXC_RI      = 2;
    localparam int EXC_OV      = 3;
    localparam int EXC_TRAP    = 4;
    localparam int EXC_ERET    = 5;
    localparam int EXC_ADEL    = 6;
    localparam int EXC_ADES    = 7;

    // mem_flags = {adel_fetch, ri, syscall, brk, ov, trap, eret, adel_data, ades_data}
    localparam int FLG_ADES_DATA  = 0;
    localparam int FLG_ADEL_DATA  = 1;
    localparam int FLG_ERET       = 2;
    localparam int FLG_TRAP       = 3;
    localparam int FLG_OV         = 4;
    localparam int FLG_BRK        = 5;
    localparam int FLG_SYSCALL    = 6;
    localparam int FLG_RI         = 7;
    localparam int FLG_ADEL_FETCH = 8;

    // Source of badvaddr for the selected exception
    localparam logic [1:0] BADV_NONE  = 2'd0;
    localparam logic [1:0] BADV_PC    = 2'd1;
    localparam logic [1:0] BADV_DADDR = 2'd2;

    // Requester FSM
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - 9-bit exception priority to one-hot encoder
//
// Ports:
//   flags_i    [8:0] per-instruction exception flags (mem_flags layout)
//   onehot_o   [7:0] exc_type one-hot of the highest-priority flag, 0 if none
//   badv_sel_o [1:0] which address feeds badvaddr (BADV_* codes)
module exc_prio_enc
    import exc_requester_pkg::*;
(
    input  logic [8:0] flags_i,
    output logic [7:0] onehot_o,
    output logic [1:0] badv_sel_o
);

    // Fetch-side faults outrank decode faults, which outrank execute and
    // data-access faults; both address errors on load map to the AdEL bit.
    always_comb begin
        onehot_o   = 8'h00;
        badv_sel_o = BADV_NONE;
        if (flags_i[FLG_ADEL_FETCH]) begin
            onehot_o[EXC_ADEL] = 1'b1;
            badv_sel_o         = BADV_PC;
        end else if (flags_i[FLG_RI]) begin
            onehot_o[EXC_RI] = 1'b1;
        end else if (flags_i[FLG_SYSCALL]) begin
            onehot_o[EXC_SYSCALL] = 1'b1;
        end else if (flags_i[FLG_BRK]) begin
            onehot_o[EXC_BRK] = 1'b1;
        end else if (flags_i[FLG_OV]) begin
            onehot_o[EXC_OV] = 1'b1;
        end else if (flags_i[FLG_TRAP]) begin
            onehot_o[EXC_TRAP] = 1'b1;
        end else if (flags_i[FLG_ERET]) begin
            onehot_o[EXC_ERET] = 1'b1;
        end else if (flags_i[FLG_ADEL_DATA]) begin
            onehot_o[EXC_ADEL] = 1'b1;
            badv_sel_o         = BADV_DADDR;
        end else if (flags_i[FLG_ADES_DATA]) begin
            onehot_o[EXC_ADES] = 1'b1;
            badv_sel_o         = BADV_DADDR;
        end
    end

endmodule

// File: rtl/exc_requester.sv
// rtl/exc_requester.sv - MEM-stage exception requester toward CP0
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_valid/mem_stall        MEM holds a real instruction / it is not advancing
//   mem_pc, mem_daddr          instruction PC and data virtual address
//   mem_is_delayslot/branch    delay-slot and branch markers of the MEM instruction
//   mem_flags [8:0]            exception flags
//   exc_en, PC_exc             CP0 acceptance and target (same cycle)
//   if_ready                   fetch accepts the redirect
//   exc_type, victim_inst_addr, is_delayslot, badvaddr   request to CP0
//   flush                      kill IF..MEM this cycle
//   redirect_valid/redirect_pc held fetch redirect
module exc_requester
    import exc_requester_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_stall,
    input  logic [31:0] mem_pc,
    input  logic        mem_is_delayslot,
    input  logic        mem_is_branch,
    input  logic [8:0]  mem_flags,
    input  logic [31:0] mem_daddr,
    input  logic        exc_en,
    input  logic [31:0] PC_exc,
    input  logic        if_ready,
    output logic [7:0]  exc_type,
    output logic [31:0] victim_inst_addr,
    output logic        is_delayslot,
    output logic [31:0] badvaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic [0:0]  state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic        br_q, br_d;

    logic [7:0]  enc_onehot;
    logic [1:0]  enc_badv_sel;
    logic        in_run;
    logic        raise_ok;
    logic        commit;

    exc_prio_enc u_enc (
        .flags_i    (mem_flags),
        .onehot_o   (enc_onehot),
        .badv_sel_o (enc_badv_sel)
    );

    assign in_run = (state_q == ST_RUN) && !rst;

    // Only an advancing instruction in RUN may raise, so a stalled or
    // already-flushed instruction is never reported to CP0 twice.
    assign raise_ok = in_run && mem_valid && !mem_stall;

    assign exc_type = raise_ok ? enc_onehot : 8'h00;

    always_comb begin
        badvaddr = 32'h0;
        if (raise_ok) begin
            case (enc_badv_sel)
                BADV_PC:    badvaddr = mem_pc;
                BADV_DADDR: badvaddr = mem_daddr;
                default:    badvaddr = 32'h0;
            endcase
        end
    end

    // Interrupts arrive with exc_type = 0 and may be taken under stall,
    // so acceptance depends only on RUN and exc_en.
    assign flush = in_run && exc_en;

    // In a bubble the interrupt victim is the next instruction to commit.
    assign victim_inst_addr = mem_valid ? mem_pc : next_pc_q;
    assign is_delayslot     = mem_valid ? mem_is_delayslot : br_q;

    assign commit = mem_valid && !mem_stall && !flush;

    assign redirect_valid = (state_q == ST_HOLD);
    assign redirect_pc    = redirect_pc_q;

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        next_pc_d     = next_pc_q;
        br_d          = br_q;

        if (commit) begin
            next_pc_d = mem_pc + 32'd4;
            br_d      = mem_is_branch;
        end

        case (state_q)
            ST_RUN: begin
                if (exc_en) begin
                    state_d       = ST_HOLD;
                    redirect_pc_d = PC_exc;
                end
            end
            ST_HOLD: begin
                // Fetch resumes at the redirect target, which becomes the
                // next committing PC; it is never in a delay slot.
                if (if_ready) begin
                    state_d   = ST_RUN;
                    next_pc_d = redirect_pc_q;
                    br_d      = 1'b0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            redirect_pc_q <= 32'h0;
            next_pc_q     <= RESET_PC;
            br_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            next_pc_q     <= next_pc_d;
            br_q          <= br_d;
        end
    end

endmodule

// File: tb/tb_exc_requester.sv
// tb/tb_exc_requester.sv - self-checking bench for exc_requester
module tb_exc_requester;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_stall;
    logic [31:0] mem_pc;
    logic        mem_is_delayslot;
    logic        mem_is_branch;
    logic [8:0]  mem_flags;
    logic [31:0] mem_daddr;
    logic        exc_en;
    logic [31:0] PC_exc;
    logic        if_ready;
    logic [7:0]  exc_type;
    logic [31:0] victim_inst_addr;
    logic        is_delayslot;
    logic [31:0] badvaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp;
    int n_fail;

    exc_requester dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_stall        (mem_stall),
        .mem_pc           (mem_pc),
        .mem_is_delayslot (mem_is_delayslot),
        .mem_is_branch    (mem_is_branch),
        .mem_flags        (mem_flags),
        .mem_daddr        (mem_daddr),
        .exc_en           (exc_en),
        .PC_exc           (PC_exc),
        .if_ready         (if_ready),
        .exc_type         (exc_type),
        .victim_inst_addr (victim_inst_addr),
        .is_delayslot     (is_delayslot),
        .badvaddr         (badvaddr),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ds;
        logic [31:0] pc;
        logic [31:0] daddr;
        logic [8:0]  flags;
        logic [7:0]  e_type;
        logic [31:0] e_badv;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_stall = 1'b0; mem_pc = 32'h0;
        mem_is_delayslot = 1'b0; mem_is_branch = 1'b0; mem_flags = 9'h0;
        mem_daddr = 32'h0; exc_en = 1'b0; PC_exc = 32'h0; if_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;

        //            stall ds  pc            daddr         flags          type   badv
        vecs[0]  = '{1'b0, 1'b0, 32'h80001000, 32'h00001234, 9'b000010001, 8'h08, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h80000002, 32'h0,        9'b100000000, 8'h40, 32'h80000002};
        vecs[2]  = '{1'b0, 1'b0, 32'h80000020, 32'h80000013, 9'b000000001, 8'h80, 32'h80000013};
        vecs[3]  = '{1'b0, 1'b0, 32'h80000024, 32'h80000011, 9'b000000010, 8'h40, 32'h80000011};
        vecs[4]  = '{1'b0, 1'b0, 32'h80000028, 32'h0,        9'b011000000, 8'h04, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h8000002c, 32'h0,        9'b001100000, 8'h02, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h80000030, 32'h0,        9'b000110000, 8'h01, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h80000034, 32'h0,        9'b000001100, 8'h10, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h80000038, 32'h80000099, 9'b000000110, 8'h20, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h8000003c, 32'h80000055, 9'b111111111, 8'h40, 32'h8000003c};
        vecs[10] = '{1'b0, 1'b0, 32'h80000040, 32'h80000044, 9'b000000000, 8'h00, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h80000044, 32'h80000048, 9'b010000000, 8'h00, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 32'h80000048, 32'h0,        9'b000100001, 8'h01, 32'h0};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_exc_type", exc_type, 8'h00);
        chk("rst_flush", flush, 1'b0);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_victim", victim_inst_addr, 32'hbfc00000);
        chk("rst_ds", is_delayslot, 1'b0);
        tick();

        // Priority / badvaddr table, CP0 idle
        for (int i = 0; i < 13; i++) begin
            mem_valid = 1'b1;
            mem_stall = vecs[i].stall;
            mem_is_delayslot = vecs[i].ds;
            mem_pc = vecs[i].pc;
            mem_daddr = vecs[i].daddr;
            mem_flags = vecs[i].flags;
            @(negedge clk);
            chk($sformatf("vec%0d_exc_type", i), exc_type, vecs[i].e_type);
            chk($sformatf("vec%0d_badvaddr", i), badvaddr, vecs[i].e_badv);
            chk($sformatf("vec%0d_victim", i), victim_inst_addr, vecs[i].pc);
            chk($sformatf("vec%0d_ds", i), is_delayslot, vecs[i].ds);
            chk($sformatf("vec%0d_flush", i), flush, 1'b0);
            tick();
        end

        // Accepted exception: one-cycle flush, held redirect until if_ready
        idle_inputs();
        mem_valid = 1'b1; mem_pc = 32'h80001000; mem_flags = 9'b000010001;
        exc_en = 1'b1; PC_exc = 32'hbfc00380;
        @(negedge clk);
        chk("t1_exc_type", exc_type, 8'h08);
        chk("t1_badvaddr", badvaddr, 32'h0);
        chk("t1_flush", flush, 1'b1);
        chk("t1_rv_before", redirect_valid, 1'b0);
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("t1_hold%0d_rv", i), redirect_valid, 1'b1);
            chk($sformatf("t1_hold%0d_rpc", i), redirect_pc, 32'hbfc00380);
            chk($sformatf("t1_hold%0d_flush", i), flush, 1'b0);
            tick();
        end
        if_ready = 1'b1;
        @(negedge clk);
        chk("t1_ready_rv", redirect_valid, 1'b1);
        tick();
        if_ready = 1'b0;
        @(negedge clk);
        chk("t1_done_rv", redirect_valid, 1'b0);
        chk("t1_done_victim", victim_inst_addr, 32'hbfc00380);
        chk("t1_done_ds", is_delayslot, 1'b0);
        tick();

        // Stalled excepting instruction raises only once it advances
        idle_inputs();
        mem_valid = 1'b1; mem_pc = 32'h80000200; mem_flags = 9'b010000000;
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t3_stall%0d_exc_type", i), exc_type, 8'h00);
            tick();
        end
        mem_stall = 1'b0;
        @(negedge clk);
        chk("t3_release_exc_type", exc_type, 8'h04);
        tick();
        mem_pc = 32'h80000204; mem_flags = 9'h0;
        @(negedge clk);
        chk("t3_after_exc_type", exc_type, 8'h00);
        tick();

        // Branch commits, then bubble interrupt reports its delay slot
        idle_inputs();
        mem_valid = 1'b1; mem_pc = 32'h80000100; mem_is_branch = 1'b1;
        tick();
        idle_inputs();
        exc_en = 1'b1; PC_exc = 32'hbfc00380;
        @(negedge clk);
        chk("t4_victim", victim_inst_addr, 32'h80000104);
        chk("t4_ds", is_delayslot, 1'b1);
        chk("t4_flush", flush, 1'b1);
        chk("t4_exc_type", exc_type, 8'h00);
        tick();

        // HOLD with exc_en kept high and fetch not ready
        mem_valid = 1'b1; mem_pc = 32'h80000300; mem_flags = 9'b010000000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("t5_hold%0d_rv", i), redirect_valid, 1'b1);
            chk($sformatf("t5_hold%0d_flush", i), flush, 1'b0);
            chk($sformatf("t5_hold%0d_exc_type", i), exc_type, 8'h00);
            tick();
        end

        // Reset while in HOLD
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rv", redirect_valid, 1'b0);
        chk("t6_flush", flush, 1'b0);
        chk("t6_rpc", redirect_pc, 32'h0);
        tick();
        exc_en = 1'b1; PC_exc = 32'hbfc00380;
        @(negedge clk);
        chk("t6_irq_flush", flush, 1'b1);
        chk("t6_irq_victim", victim_inst_addr, 32'hbfc00000);
        chk("t6_irq_ds", is_delayslot, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("t6_irq_rv", redirect_valid, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_requester.md
# exc_requester

Exception requester for the MEM stage, on the initiator side of the CP0 exception interface. Gathers per-instruction exception flags from the MEM stage, picks one by priority and drives the one-hot `exc_type`, `victim_inst_addr`, `is_delayslot` and `badvaddr` into the CP0 block. It then takes CP0's `exc_en`/`PC_exc` answer and turns it into a pipeline flush plus a held fetch redirect. It also tracks the victim address for interrupts that arrive while MEM holds a bubble.

## Interface
- `RESET_PC`, default 32'hbfc00000: victim address reported before any instruction has committed.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_valid` in 1: MEM holds a real instruction.
- `mem_stall` in 1: MEM instruction not advancing this cycle.
- `mem_pc` in 32: MEM instruction PC.
- `mem_is_delayslot` in 1: MEM instruction sits in a branch delay slot.
- `mem_is_branch` in 1: MEM instruction is a branch or jump.
- `mem_flags` in 9: {adel_fetch, ri, syscall, brk, ov, trap, eret, adel_data, ades_data}.
- `mem_daddr` in 32: MEM data virtual address.
- `exc_en` in 1: CP0 accepts an exception or interrupt (combinational, same cycle).
- `PC_exc` in 32: CP0 target address.
- `if_ready` in 1: fetch accepts a redirect.
- `exc_type` out 8: one-hot to CP0. bit6 AdEL, bit7 AdES, bit1 syscall, bit0 break, bit2 RI, bit3 Ov, bit4 trap, bit5 eret.
- `victim_inst_addr` out 32: victim PC.
- `is_delayslot` out 1: victim is in a delay slot.
- `badvaddr` out 32: faulting virtual address.
- `flush` out 1: kill IF..MEM this cycle.
- `redirect_valid` out 1: redirect pending.
- `redirect_pc` out 32: redirect target.

## Operation
- **Selection.** Only one bit of `exc_type` is ever set, chosen in this priority order:
  - adel_fetch → bit6
  - ri → bit2
  - syscall → bit1
  - brk → bit0
  - ov → bit3
  - trap → bit4
  - eret → bit5
  - adel_data → bit6
  - ades_data → bit7
- **Gating.** `exc_type` is 0 unless all of the following hold: `mem_valid`, `!mem_stall`, and state is RUN. This guarantees CP0 commits each exception exactly once.
- **badvaddr.**
  - `mem_pc` for adel_fetch.
  - `mem_daddr` for adel_data and ades_data.
  - 0 otherwise.
- **Victim.**
  - When `mem_valid`: `victim_inst_addr` = `mem_pc` and `is_delayslot` = `mem_is_delayslot`.
  - Otherwise: `victim_inst_addr` = `next_pc_r` and `is_delayslot` = `br_r`.
  - On every cycle with `mem_valid && !mem_stall && !flush`: `next_pc_r` ← `mem_pc`+4 and `br_r` ← `mem_is_branch`.
- **FSM.**
  - **RUN:**
    - If `exc_en`: `flush` = 1 in this same cycle, `redirect_pc` ← `PC_exc`, go to HOLD.
    - If `exc_en` is high with `exc_type` = 0 (an interrupt), take the same path even when `mem_stall` = 1.
  - **HOLD:**
    - `redirect_valid` = 1 and `flush` = 0.
    - If `if_ready`, go to RUN.
    - `exc_en` is ignored while in HOLD.
  - **After redirect.** Once the redirect completes: `next_pc_r` ← `redirect_pc` and `br_r` ← 0.
- **Reset values.**
  - State RUN.
  - `next_pc_r` = `RESET_PC`, `br_r` = 0.
  - `redirect_pc` = 0, `redirect_valid` = 0, `flush` = 0, `exc_type` = 0.

## Timing
- **Same-cycle path.** `exc_type`, `victim_inst_addr`, `is_delayslot`, `badvaddr` and `flush` are combinational from the inputs. CP0's cause/`exc_en` path is combinational in the same cycle T.
- **Redirect.** `redirect_valid` rises in T+1 and falls in the cycle after `if_ready` is sampled high.
  - Minimum hold time: 1 cycle.
  - No upper bound on hold time.
- **Back-to-back.** A new exception can be raised no earlier than the first RUN cycle after HOLD, which is T+2 at the earliest.
- **Reset mid-HOLD.** Reset drops the pending redirect and returns to RUN in the next cycle.
- **Stall.** A stalled excepting instruction raises nothing. It raises in the first cycle after `mem_stall` falls.

## Structure
- A shared package holds:
  - The `exc_type` bit-index constants.
  - The `mem_flags` index constants.
  - The FSM state encoding (RUN=0, HOLD=1).
  - `EXC_VECTOR` = 32'hbfc00380.
- One natural sub-module: `exc_prio_enc`, a 9-bit priority to one-hot encoder that also produces the badvaddr select.

## Test plan
1. `mem_flags` = ov|ades_data with `mem_pc` = 0x80001000 → `exc_type` = 8'h08, `badvaddr` = 0. `exc_en`=1 and `PC_exc`=0xbfc00380 → `flush` for 1 cycle, then `redirect_valid` with `redirect_pc` = 0xbfc00380 until `if_ready`.
2. adel_fetch with `mem_pc` = 0x80000002 → `exc_type` = 8'h40, `badvaddr` = 0x80000002. With ades_data and `mem_daddr` = 0x80000013 → 8'h80, `badvaddr` = 0x80000013.
3. Excepting instruction held under `mem_stall` for 3 cycles → `exc_type` = 0 for 3 cycles, then nonzero for exactly 1 cycle.
4. Branch at 0x80000100 commits, MEM bubble, CP0 raises interrupt → `victim_inst_addr` = 0x80000104, `is_delayslot` = 1, `flush` = 1.
5. Keep `if_ready` = 0 for 4 cycles while in HOLD with `exc_en` = 1 → `redirect_valid` held, no second flush, `exc_type` = 0.
6. Assert `rst` during HOLD → `redirect_valid` = 0 and `flush` = 0 next cycle. First bubble interrupt then reports 0xbfc00000.
